// File: rtl/branch_pkg.sv
// Shared types and constants for the branch resolution stage.
package branch_pkg;

    // Conditional-branch encodings carried in funct3. 010 and 011 are unused.
    typedef enum logic [2:0] {
        BR_BEQ  = 3'b000,
        BR_BNE  = 3'b001,
        BR_BLT  = 3'b100,
        BR_BGE  = 3'b101,
        BR_BLTU = 3'b110,
        BR_BGEU = 3'b111
    } br_funct3_e;

    // Byte distance from a branch to its sequential successor.
    localparam int unsigned PC_STEP = 4;

    // Output register occupancy.
    typedef logic [0:0] state_t;
    localparam state_t ST_EMPTY = 1'b0;
    localparam state_t ST_FULL  = 1'b1;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluation: compares rs1/rs2 and selects
// the outcome for the given funct3. Unused encodings are flagged illegal
// and never taken.
module branch_cond_eval
    import branch_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [2:0]   funct3_i,
    input  logic [W-1:0] rs1_i,
    input  logic [W-1:0] rs2_i,
    output logic         taken_o,
    output logic         illegal_o
);

    logic signed [W-1:0] rs1_s;
    logic signed [W-1:0] rs2_s;
    logic                eq;
    logic                lts;
    logic                ltu;

    assign rs1_s = rs1_i;
    assign rs2_s = rs2_i;
    assign eq    = (rs1_i == rs2_i);
    assign lts   = (rs1_s < rs2_s);
    assign ltu   = (rs1_i < rs2_i);

    // Select the branch condition encoded by funct3.
    always_comb begin
        taken_o   = 1'b0;
        illegal_o = 1'b0;
        case (funct3_i)
            BR_BEQ:  taken_o = eq;
            BR_BNE:  taken_o = !eq;
            BR_BLT:  taken_o = lts;
            BR_BGE:  taken_o = !lts;
            BR_BLTU: taken_o = ltu;
            BR_BGEU: taken_o = !ltu;
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Registered branch resolution stage: evaluates the branch, computes target
// and fall-through, flags a redirect against the prediction, and holds the
// result in a one-entry valid/ready output register. Saturating counters
// track retired taken branches and retired redirects.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int W     = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             cnt_clr_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [2:0]       funct3_i,
    input  logic [W-1:0]     rs1_i,
    input  logic [W-1:0]     rs2_i,
    input  logic [W-1:0]     pc_i,
    input  logic [W-1:0]     imm_i,
    input  logic             pred_taken_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             taken_o,
    output logic [W-1:0]     target_o,
    output logic             redirect_o,
    output logic [W-1:0]     redirect_pc_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] taken_cnt_o,
    output logic [CNT_W-1:0] mispred_cnt_o
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Stage p0: combinational resolution of the incoming branch
    logic         taken_p0;
    logic         illegal_p0;
    logic         redirect_p0;
    logic [W-1:0] target_p0;
    logic [W-1:0] fall_p0;
    logic [W-1:0] rpc_p0;

    branch_cond_eval #(.W(W)) u_cond (
        .funct3_i  (funct3_i),
        .rs1_i     (rs1_i),
        .rs2_i     (rs2_i),
        .taken_o   (taken_p0),
        .illegal_o (illegal_p0)
    );

    assign target_p0   = pc_i + imm_i;
    assign fall_p0     = pc_i + W'(PC_STEP);
    assign redirect_p0 = taken_p0 ^ pred_taken_i;
    assign rpc_p0      = taken_p0 ? target_p0 : fall_p0;

    // Stage p1: output register and handshake
    state_t       state_p1;
    logic         vld_p1;
    logic         taken_p1;
    logic         illegal_p1;
    logic         redirect_p1;
    logic [W-1:0] target_p1;
    logic [W-1:0] rpc_p1;
    logic         accept;
    logic         retire;

    logic [CNT_W-1:0] taken_cnt_q;
    logic [CNT_W-1:0] mispred_cnt_q;

    assign vld_p1     = (state_p1 == ST_FULL);
    assign in_ready_o = !flush_i && (!vld_p1 || out_ready_i);
    assign accept     = in_valid_i && in_ready_o;
    assign retire     = vld_p1 && out_ready_i;

    // Occupancy: flush empties, accept fills, lone retire drains.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_p1 <= ST_EMPTY;
        end else if (flush_i) begin
            state_p1 <= ST_EMPTY;
        end else if (accept) begin
            state_p1 <= ST_FULL;
        end else if (retire) begin
            state_p1 <= ST_EMPTY;
        end
    end

    // Result payload loads on accept and holds otherwise.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            taken_p1    <= 1'b0;
            illegal_p1  <= 1'b0;
            redirect_p1 <= 1'b0;
            target_p1   <= '0;
            rpc_p1      <= '0;
        end else if (accept) begin
            taken_p1    <= taken_p0;
            illegal_p1  <= illegal_p0;
            redirect_p1 <= redirect_p0;
            target_p1   <= target_p0;
            rpc_p1      <= rpc_p0;
        end
    end

    // Performance counters count retiring entries; clear wins over increment.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            taken_cnt_q   <= '0;
            mispred_cnt_q <= '0;
        end else if (cnt_clr_i) begin
            taken_cnt_q   <= '0;
            mispred_cnt_q <= '0;
        end else if (retire) begin
            if (taken_p1)    taken_cnt_q   <= sat_inc(taken_cnt_q);
            if (redirect_p1) mispred_cnt_q <= sat_inc(mispred_cnt_q);
        end
    end

    assign out_valid_o   = vld_p1;
    assign taken_o       = taken_p1;
    assign illegal_o     = illegal_p1;
    assign redirect_o    = redirect_p1;
    assign target_o      = target_p1;
    assign redirect_pc_o = rpc_p1;
    assign taken_cnt_o   = taken_cnt_q;
    assign mispred_cnt_o = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit (W=32, CNT_W=4 so saturation is reachable).
module tb_branch_resolve_unit;

    localparam int W     = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             cnt_clr;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       funct3;
    logic [W-1:0]     rs1, rs2, pc, imm;
    logic             pred;
    logic             out_valid;
    logic             out_ready;
    logic             taken;
    logic [W-1:0]     target;
    logic             redirect;
    logic [W-1:0]     redirect_pc;
    logic             illegal;
    logic [CNT_W-1:0] taken_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    always #5 clk = ~clk;

    branch_resolve_unit #(.W(W), .CNT_W(CNT_W)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .flush_i       (flush),
        .cnt_clr_i     (cnt_clr),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .funct3_i      (funct3),
        .rs1_i         (rs1),
        .rs2_i         (rs2),
        .pc_i          (pc),
        .imm_i         (imm),
        .pred_taken_i  (pred),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .taken_o       (taken),
        .target_o      (target),
        .redirect_o    (redirect),
        .redirect_pc_o (redirect_pc),
        .illegal_o     (illegal),
        .taken_cnt_o   (taken_cnt),
        .mispred_cnt_o (mispred_cnt)
    );

    typedef struct {
        logic [2:0]   f3;
        logic [31:0]  a, b, p, i;
        logic         pr;
        logic         e_taken;
        logic [31:0]  e_target;
        logic         e_redir;
        logic [31:0]  e_rpc;
        logic         e_ill;
    } vec_t;

    vec_t vecs [12];
    int   checks = 0;
    int   errors = 0;
    int   m_taken = 0;
    int   m_mis   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= 15) ? 15 : v + 1;
    endfunction

    task automatic drive(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] p, input logic [31:0] i, input logic pr);
        funct3 = f; rs1 = a; rs2 = b; pc = p; imm = i; pred = pr;
    endtask

    task automatic chk_cnt(input string name);
        chk({name, " taken_cnt"}, 32'(taken_cnt), 32'(m_taken));
        chk({name, " mispred_cnt"}, 32'(mispred_cnt), 32'(m_mis));
    endtask

    initial begin
        vecs[0]  = '{3'b100, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0, 1'b1, 32'h120, 1'b1, 32'h120, 1'b0};
        vecs[1]  = '{3'b110, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b1, 1'b0, 32'h120, 1'b1, 32'h104, 1'b0};
        vecs[2]  = '{3'b010, 32'h5, 32'h5, 32'h200, 32'h10, 1'b0, 1'b0, 32'h210, 1'b0, 32'h204, 1'b1};
        vecs[3]  = '{3'b011, 32'h5, 32'h5, 32'h300, 32'h40, 1'b1, 1'b0, 32'h340, 1'b1, 32'h304, 1'b1};
        vecs[4]  = '{3'b000, 32'h5, 32'h5, 32'hFFFF_FFFC, 32'h8, 1'b1, 1'b1, 32'h4, 1'b0, 32'h4, 1'b0};
        vecs[5]  = '{3'b001, 32'h5, 32'h5, 32'hFFFF_FFFC, 32'h8, 1'b1, 1'b0, 32'h4, 1'b1, 32'h0, 1'b0};
        vecs[6]  = '{3'b101, 32'hFFFF_FFFF, 32'h1, 32'h1000, 32'hFFFF_FFF0, 1'b0, 1'b0, 32'hFF0, 1'b0, 32'h1004, 1'b0};
        vecs[7]  = '{3'b111, 32'hFFFF_FFFF, 32'h1, 32'h1000, 32'hFFFF_FFF0, 1'b1, 1'b1, 32'hFF0, 1'b0, 32'hFF0, 1'b0};
        vecs[8]  = '{3'b100, 32'h8000_0000, 32'h7FFF_FFFF, 32'h40, 32'h80, 1'b1, 1'b1, 32'hC0, 1'b0, 32'hC0, 1'b0};
        vecs[9]  = '{3'b110, 32'h8000_0000, 32'h7FFF_FFFF, 32'h40, 32'h80, 1'b0, 1'b0, 32'hC0, 1'b0, 32'h44, 1'b0};
        vecs[10] = '{3'b001, 32'h1, 32'h2, 32'h500, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'h4FC, 1'b1, 32'h4FC, 1'b0};
        vecs[11] = '{3'b101, 32'h3, 32'h3, 32'h10, 32'h10, 1'b0, 1'b1, 32'h20, 1'b1, 32'h20, 1'b0};

        rst_n = 1'b0; flush = 1'b0; cnt_clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        drive(3'b000, 0, 0, 0, 0, 1'b0);

        // Reset state
        #12;
        chk("rst out_valid", 32'(out_valid), 0);
        chk("rst taken", 32'(taken), 0);
        chk("rst redirect", 32'(redirect), 0);
        chk("rst illegal", 32'(illegal), 0);
        chk("rst target", target, 0);
        chk("rst redirect_pc", redirect_pc, 0);
        chk_cnt("rst");
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk("post-rst in_ready", 32'(in_ready), 1);

        // Table: one transaction per vector, retired the following edge
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            drive(vecs[k].f3, vecs[k].a, vecs[k].b, vecs[k].p, vecs[k].i, vecs[k].pr);
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            chk($sformatf("v%0d out_valid", k), 32'(out_valid), 1);
            chk($sformatf("v%0d taken", k), 32'(taken), 32'(vecs[k].e_taken));
            chk($sformatf("v%0d target", k), target, vecs[k].e_target);
            chk($sformatf("v%0d redirect", k), 32'(redirect), 32'(vecs[k].e_redir));
            chk($sformatf("v%0d redirect_pc", k), redirect_pc, vecs[k].e_rpc);
            chk($sformatf("v%0d illegal", k), 32'(illegal), 32'(vecs[k].e_ill));
            if (vecs[k].e_taken) m_taken = sat(m_taken);
            if (vecs[k].e_redir) m_mis = sat(m_mis);
            @(negedge clk);
            chk($sformatf("v%0d drained", k), 32'(out_valid), 0);
            chk_cnt($sformatf("v%0d", k));
        end

        // Clear counters so the remaining sequences start from zero
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        m_taken = 0; m_mis = 0;
        chk_cnt("clr idle");

        // Back-pressure: hold A while B waits at the input
        drive(3'b000, 32'h1, 32'h1, 32'h100, 32'h8, 1'b0);   // A: taken, redirect, 0x108
        in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        drive(3'b001, 32'h1, 32'h1, 32'h200, 32'h10, 1'b0);  // B: not taken, 0x204
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("bp%0d out_valid", c), 32'(out_valid), 1);
            chk($sformatf("bp%0d in_ready", c), 32'(in_ready), 0);
            chk($sformatf("bp%0d target", c), target, 32'h108);
            chk($sformatf("bp%0d redirect_pc", c), redirect_pc, 32'h108);
            chk($sformatf("bp%0d taken", c), 32'(taken), 1);
            chk_cnt($sformatf("bp%0d", c));
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        chk("bp release in_ready", 32'(in_ready), 1);
        @(negedge clk);
        m_taken = sat(m_taken); m_mis = sat(m_mis);
        chk("b2b B out_valid", 32'(out_valid), 1);
        chk("b2b B target", target, 32'h210);
        chk("b2b B redirect_pc", redirect_pc, 32'h204);
        chk("b2b B taken", 32'(taken), 0);
        chk_cnt("b2b A retired");
        drive(3'b110, 32'h0, 32'h1, 32'h300, 32'h4, 1'b1);   // C: taken, predicted
        @(negedge clk);
        chk("b2b C out_valid", 32'(out_valid), 1);
        chk("b2b C target", target, 32'h304);
        chk("b2b C redirect", 32'(redirect), 0);
        chk_cnt("b2b B retired");

        // Flush while FULL without retire: entry and incoming both dropped
        drive(3'b000, 32'h2, 32'h2, 32'h400, 32'h8, 1'b0);
        out_ready = 1'b0; flush = 1'b1;
        #1;
        chk("flush in_ready", 32'(in_ready), 0);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        chk("flush out_valid", 32'(out_valid), 0);
        chk_cnt("flush");
        @(negedge clk);
        chk("flush no accept", 32'(out_valid), 0);

        // Flush coinciding with retire: the retiring entry still counts
        drive(3'b000, 32'h2, 32'h2, 32'h400, 32'h8, 1'b0);   // taken, mispredicted
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b1;
        chk("flush+ret valid before", 32'(out_valid), 1);
        @(negedge clk);
        flush = 1'b0;
        m_taken = sat(m_taken); m_mis = sat(m_mis);
        chk("flush+ret out_valid", 32'(out_valid), 0);
        chk_cnt("flush+ret");

        // Saturation: stream 17 taken, correctly predicted branches
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        m_taken = 0; m_mis = 0;
        drive(3'b000, 32'h7, 32'h7, 32'h800, 32'h10, 1'b1);
        in_valid = 1'b1;
        for (int n = 0; n < 17; n++) begin
            @(negedge clk);
            if (n > 0) m_taken = sat(m_taken);
            chk($sformatf("stream%0d out_valid", n), 32'(out_valid), 1);
        end
        in_valid = 1'b0;
        @(negedge clk);
        m_taken = sat(m_taken);
        chk("sat out_valid", 32'(out_valid), 0);
        chk("sat taken_cnt", 32'(taken_cnt), 32'd15);
        chk_cnt("sat");

        // Clear coinciding with a retire wins over the increment
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; cnt_clr = 1'b1;
        chk("clr+ret valid before", 32'(out_valid), 1);
        @(negedge clk);
        cnt_clr = 1'b0;
        chk("clr+ret taken_cnt", 32'(taken_cnt), 0);
        chk("clr+ret out_valid", 32'(out_valid), 0);

        // Reset mid-operation discards the held entry at once
        drive(3'b001, 32'h1, 32'h2, 32'h900, 32'h20, 1'b0);
        in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        chk("pre-rst out_valid", 32'(out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst out_valid", 32'(out_valid), 0);
        chk("async rst target", target, 0);
        chk("async rst taken_cnt", 32'(taken_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Parametrised, registered branch-resolution stage for the RV32 execute pipeline. It evaluates all six conditional-branch types from funct3, computes the branch target, and compares the outcome against the front-end prediction to raise a redirect. The result is held in a one-entry output register behind a valid/ready handshake with flush support. Saturating taken and mispredict counters feed the performance-counter CSRs.

## Interface
- W, 32, operand/PC/target width (≥ 8)
- CNT_W, 32, width of each performance counter
- clk_i  in  1  clock, all state on rising edge
- rst_ni  in  1  asynchronous, active-low reset
- flush_i  in  1  pipeline flush; kills held and incoming entries
- cnt_clr_i  in  1  synchronous clear of both counters
- in_valid_i  in  1  branch operands valid
- in_ready_o  out  1  stage can accept
- funct3_i  in  3  branch funct3
- rs1_i, rs2_i  in  W  compare operands
- pc_i  in  W  branch PC
- imm_i  in  W  sign-extended B-immediate
- pred_taken_i  in  1  front-end prediction
- out_valid_o  out  1  result valid
- out_ready_i  in  1  consumer accepts
- taken_o  out  1  resolved direction
- target_o  out  W  pc+imm
- redirect_o  out  1  taken_o ≠ pred_taken
- redirect_pc_o  out  W  correct next PC
- illegal_o  out  1  funct3 is 010 or 011
- taken_cnt_o  out  CNT_W  retired taken branches
- mispred_cnt_o  out  CNT_W  retired redirects

## Operation
- Conditions: eq = (rs1==rs2); lts = signed rs1<rs2; ltu = unsigned rs1<rs2.
- funct3 mapping:
  - 000 BEQ = eq; 001 BNE = !eq
  - 100 BLT = lts; 101 BGE = !lts
  - 110 BLTU = ltu; 111 BGEU = !ltu
- 010/011: illegal_o=1, taken=0.
- target = pc+imm mod 2^W; fallthrough = pc+4 mod 2^W (wrap, no carry out).
- redirect = taken XOR pred_taken. redirect_pc = taken ? target : fallthrough.
- An illegal entry still redirects when pred_taken=1.
- Output register is a two-state machine:
  - EMPTY → FULL on accept (in_valid_i && in_ready_o).
  - FULL → EMPTY on retire (out_valid_o && out_ready_i) with no new accept.
  - FULL → FULL on simultaneous retire+accept; new entry loaded.
  - Any state → EMPTY on flush_i.
- in_ready_o = !flush_i && (EMPTY || out_ready_i).
- Counters update only on retire:
  - taken_cnt +1 if taken_o.
  - mispred_cnt +1 if redirect_o.
  - Both saturate at 2^CNT_W−1.
- cnt_clr_i has priority over increment in the same cycle.
- Flushed entries are never counted.

## Timing
- Reset (async assert, sync-safe release):
  - State EMPTY; out_valid_o=0.
  - taken_o, redirect_o, illegal_o = 0.
  - target_o, redirect_pc_o = 0.
  - Both counters = 0.
  - in_ready_o=1 once rst_ni is high.
- Latency 1 cycle: inputs accepted at edge N appear on the outputs after edge N, valid during cycle N+1.
- Throughput 1 branch/cycle when out_ready_i is held high.
- Back-pressure: while FULL && !out_ready_i, all outputs hold stable and in_ready_o=0.
- Flush: out_valid_o=0 in the cycle after flush_i. No accept occurs in a flush cycle. Counters are unchanged unless a retire coincides with flush, in which case the retire counts.
- Reset asserted mid-operation discards the entry immediately; no counter update.
- Data outputs are don't-care when out_valid_o=0, except after reset.

## Structure
- Package branch_pkg holds:
  - funct3 enum: BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU.
  - Constant PC_STEP=4.
  - State typedef {ST_EMPTY, ST_FULL}.
- Sub-module branch_cond_eval (combinational, parameter W) produces eq/lts/ltu, taken and illegal from funct3.
- Top level contains the adders, output register/FSM, handshake and counters.

## Test plan
- BLT, rs1=0xFFFF_FFFF, rs2=1, pc=0x100, imm=0x20, pred=0 → next cycle taken=1, target=0x120, redirect=1, redirect_pc=0x120, mispred_cnt=1 after retire.
- BLTU, same operands, pred=1 → taken=0, redirect=1, redirect_pc=0x104, taken_cnt unchanged.
- funct3=010, pred=0 → illegal_o=1, taken=0, redirect=0. With pred=1, redirect=1 and redirect_pc=pc+4.
- Wrap: pc=0xFFFF_FFFC, BEQ with equal operands, imm=8 → target=0x4; fallthrough=0x0.
- Back-pressure: out_ready_i=0 for 3 cycles with in_valid_i=1 → in_ready_o=0 and outputs stable. Raise out_ready_i → back-to-back retire/accept with no bubble. Flush while FULL → out_valid_o=0 next cycle, counters unchanged.
- Saturation/clear: CNT_W=4, retire 17 taken branches → taken_cnt=15. Assert cnt_clr_i during a retire → counter=0.
